div_repsub: RTL and testbench

//   Unsigned integer divider by repeated subtraction; the inverse companion of the

---
 rtl/div_repsub.sv | 100 ++++++++++
 tb/tb_div_repsub.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/div_repsub.sv
// Unsigned divider by repeated subtraction. Operands arrive serially on data_in
// (dividend, then divisor); a controller FSM runs the subtract loop and reports Q/R with done.
module div_repsub #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        COMPUTE,
        DONE
    } state_t;

    state_t         state_q;
    logic [W-1:0]   q_q;
    logic [W-1:0]   r_q;
    logic [W-1:0]   b_q;
    logic           busy_q;
    logic           done_q;
    logic           dbz_q;

    // Status flags are registered alongside the state so they track it exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            r_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= LOAD_A;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD_A: begin
                    r_q     <= data_in;
                    q_q     <= '0;
                    dbz_q   <= 1'b0;
                    state_q <= LOAD_B;
                end
                LOAD_B: begin
                    b_q     <= data_in;
                    state_q <= COMPUTE;
                end
                COMPUTE: begin
                    if (b_q == '0) begin
                        dbz_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (r_q >= b_q) begin
                        // Guarded by r_q >= b_q, so neither update can wrap.
                        r_q <= r_q - b_q;
                        q_q <= q_q + 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (!start) begin
                        done_q  <= 1'b0;
                        dbz_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    dbz_q   <= 1'b0;
                end
            endcase
        end
    end

    assign quotient    = q_q;
    assign remainder   = r_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_repsub.sv
// Self-checking bench for div_repsub: expected results are queued when an operation
// is launched and compared when done rises, together with latency and flag checks.
module tb_div_repsub;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] data_in;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           cycles;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    div_repsub #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .data_in     (data_in),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one division, hold start high through DONE, then release it.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
        exp_t e;
        exp_t got;
        int   n;
        e.a = a;
        e.b = b;
        if (b == '0) begin
            e.q = '0;
            e.r = a;
            e.dbz = 1'b1;
            e.cycles = 1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.dbz = 1'b0;
            e.cycles = int'(e.q) + 1;
        end
        sb.push_back(e);

        @(posedge clk); #1;
        start = 1'b1;
        data_in = a;
        @(posedge clk); #1;                       // now in LOAD_A
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL %s load_a_flags: busy/done=%b required 10", name, {busy, done});
        end
        @(posedge clk); #1;                       // dividend captured, now in LOAD_B
        checks++;
        if (remainder !== a) begin
            errors++;
            $display("FAIL %s dividend_hold: remainder=%0d required %0d", name, remainder, a);
        end
        data_in = b;
        @(posedge clk); #1;                       // divisor captured, now in COMPUTE
        data_in = W'($urandom);
        n = 0;
        while (!done && n < 70000) begin
            @(posedge clk); #1;
            n++;
            data_in = W'($urandom);
        end
        got = sb.pop_front();
        checks++;
        if (done !== 1'b1 || n !== got.cycles) begin
            errors++;
            $display("FAIL %s latency: done=%b after %0d compute cycles, required done=1 after %0d",
                     name, done, n, got.cycles);
        end
        checks++;
        if ({quotient, remainder, div_by_zero, busy} !== {got.q, got.r, got.dbz, 1'b0}) begin
            errors++;
            $display("FAIL %s result: q=%0d r=%0d dbz=%b busy=%b required q=%0d r=%0d dbz=%b busy=0",
                     name, quotient, remainder, div_by_zero, busy, got.q, got.r, got.dbz);
        end
        $display("op %s: %0d / %0d -> q=%0d r=%0d dbz=%b in %0d compute cycles",
                 name, got.a, got.b, quotient, remainder, div_by_zero, n);

        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({done, quotient, remainder, div_by_zero} !== {1'b1, got.q, got.r, got.dbz}) begin
            errors++;
            $display("FAIL %s hold_done: done=%b q=%0d r=%0d dbz=%b required done=1 q=%0d r=%0d dbz=%b",
                     name, done, quotient, remainder, div_by_zero, got.q, got.r, got.dbz);
        end
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({done, busy, div_by_zero} !== 3'b000) begin
            errors++;
            $display("FAIL %s release: done/busy/dbz=%b required 000", name, {done, busy, div_by_zero});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({quotient, remainder, busy, done, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_state: q=%0d r=%0d busy=%b done=%b dbz=%b required all 0",
                     quotient, remainder, busy, done, div_by_zero);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset: busy/done=%b required 00", {busy, done});
        end
    endtask

    task automatic test_basic();
        run_op(16'd17, 16'd5, "17/5");
        run_op(16'd5, 16'd17, "5/17");
    endtask

    task automatic test_exact();
        run_op(16'd20, 16'd4, "20/4");
        run_op(16'd7, 16'd7, "7/7");
    endtask

    task automatic test_div_zero();
        run_op(16'd9, 16'd0, "9/0");
    endtask

    task automatic test_max();
        run_op(16'hFFFF, 16'd1, "65535/1");
    endtask

    task automatic test_reset_abort();
        @(posedge clk); #1;
        start = 1'b1;
        data_in = 16'd100;
        @(posedge clk); #1;
        @(posedge clk); #1;
        data_in = 16'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({quotient, remainder, busy, done, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL abort_reset: q=%0d r=%0d busy=%b done=%b dbz=%b required all 0",
                     quotient, remainder, busy, done, div_by_zero);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(16'd100, 16'd7, "100/7_after_reset");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 6; i++) begin
            a = W'($urandom_range(0, 3000));
            b = (i == 3) ? '0 : W'($urandom_range(1, 60));
            run_op(a, b, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_exact();
        test_div_zero();
        test_max();
        test_reset_abort();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
